// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with eight modes: hold, shift, load, rotate, clear and invert.
// The true and complement outputs both come from one register bank, so they always agree.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_b,
    output logic             sout,
    output logic             busy
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_INV   = 3'b111;

    logic [WIDTH-1:0] q_reg, q_next;
    logic             sout_reg, sout_next;
    logic             busy_reg, busy_next;

    // Each mode reads only the inputs it needs, so X on an unused d/sin_* cannot leak into q.
    always_comb begin
        q_next    = q_reg;
        sout_next = sout_reg;
        busy_next = 1'b0;
        if (en) begin
            busy_next = (mode != MODE_HOLD);
            case (mode)
                MODE_HOLD: begin
                    q_next = q_reg;
                end
                MODE_SHR: begin
                    q_next    = {sin_r, q_reg[WIDTH-1:1]};
                    sout_next = q_reg[0];
                end
                MODE_SHL: begin
                    q_next    = {q_reg[WIDTH-2:0], sin_l};
                    sout_next = q_reg[WIDTH-1];
                end
                MODE_LOAD: begin
                    q_next = d;
                end
                MODE_ROR: begin
                    q_next    = {q_reg[0], q_reg[WIDTH-1:1]};
                    sout_next = q_reg[0];
                end
                MODE_ROL: begin
                    q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                    sout_next = q_reg[WIDTH-1];
                end
                MODE_CLEAR: begin
                    q_next    = '0;
                    sout_next = 1'b0;
                end
                MODE_INV: begin
                    q_next = ~q_reg;
                end
                default: begin
                    q_next = q_reg;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg    <= RESET_VAL;
            sout_reg <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            sout_reg <= sout_next;
            busy_reg <= busy_next;
        end
    end

    assign q    = q_reg;
    assign sout = sout_reg;
    assign busy = busy_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_qb
            assign q_b[gi] = ~q_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a behavioural model pushes expected outputs to a
// scoreboard as each step is driven, and they are popped and compared after the edge.
module tb_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RVAL = 8'hA5;

    logic         clk = 1'b0;
    logic         rst, en, sin_r, sin_l;
    logic [2:0]   mode;
    logic [W-1:0] d, q, q_b;
    logic         sout, busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] q_b;
        logic         sout;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] m_q;
    logic         m_sout;
    logic [W-1:0] rl_pat;
    logic [W-1:0] sr_pat;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l),
        .q(q), .q_b(q_b), .sout(sout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Drive one step, predict with the model, clock it, then check the scoreboard entry.
    task automatic step(input string tag, input logic r, input logic e, input logic [2:0] md,
                        input logic [W-1:0] dd, input logic sr, input logic sl);
        exp_t ex;
        logic m_busy;
        rst = r; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl;
        m_busy = 1'b0;
        if (r) begin
            m_q = RVAL;
            m_sout = 1'b0;
        end else if (e) begin
            m_busy = (md != 3'd0);
            case (md)
                3'd1: begin m_sout = m_q[0];   m_q = (m_q >> 1) | ({7'd0, sr} << 7); end
                3'd2: begin m_sout = m_q[7];   m_q = (m_q << 1) | {7'd0, sl}; end
                3'd3: m_q = dd;
                3'd4: begin m_sout = m_q[0];   m_q = (m_q >> 1) | (m_q << 7); end
                3'd5: begin m_sout = m_q[7];   m_q = (m_q << 1) | (m_q >> 7); end
                3'd6: begin m_sout = 1'b0;     m_q = 8'h00; end
                3'd7: m_q = m_q ^ 8'hFF;
                default: ;
            endcase
        end
        ex.q = m_q; ex.q_b = m_q ^ 8'hFF; ex.sout = m_sout; ex.busy = m_busy;
        exp_q.push_back(ex);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        chk({tag, ".q"}, q, ex.q);
        chk({tag, ".q_b"}, q_b, ex.q_b);
        chk({tag, ".sout"}, {7'd0, sout}, {7'd0, ex.sout});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, ex.busy});
        $display("step %-10s rst=%b en=%b mode=%0d d=%h -> q=%h q_b=%h sout=%b busy=%b",
                 tag, r, e, md, dd, q, q_b, sout, busy);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin_r = 1'b0; sin_l = 1'b0;
        m_q = '0; m_sout = 1'b0;
        rl_pat = 8'b1001_0110;
        sr_pat = 8'b1101_0010;

        // Reset wins over a simultaneous load.
        step("reset", 1'b1, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0);
        chk("reset_q", q, 8'hA5);
        chk("reset_qb", q_b, 8'h5A);
        chk("reset_busy", {7'd0, busy}, 8'd0);

        step("load81", 1'b0, 1'b1, 3'd3, 8'h81, 1'b0, 1'b0);
        chk("load81_q", q, 8'h81);
        step("shr", 1'b0, 1'b1, 3'd1, 8'hx, 1'b0, 1'bx);
        chk("shr_q", q, 8'h40);
        chk("shr_sout", {7'd0, sout}, 8'd1);
        step("shl", 1'b0, 1'b1, 3'd2, 8'hx, 1'bx, 1'b1);
        chk("shl_q", q, 8'h81);
        chk("shl_sout", {7'd0, sout}, 8'd0);

        // Rotate left a full width returns the original value.
        step("load96", 1'b0, 1'b1, 3'd3, 8'h96, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            step("rol", 1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0);
            chk("rol_sout", {7'd0, sout}, {7'd0, rl_pat[W-1-i]});
            chk("rol_busy", {7'd0, busy}, 8'd1);
        end
        chk("rol_wrap", q, 8'h96);

        step("load3c", 1'b0, 1'b1, 3'd3, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("en0_clr", 1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
            chk("en0_q", q, 8'h3C);
            chk("en0_busy", {7'd0, busy}, 8'd0);
        end
        step("invert", 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0);
        chk("inv_q", q, 8'hC3);
        chk("inv_qb", q_b, 8'h3C);

        // Serial fill from a cleared register.
        step("clear", 1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
        chk("clear_q", q, 8'h00);
        for (int i = 0; i < W; i++)
            step("fill", 1'b0, 1'b1, 3'd1, 8'h00, sr_pat[W-1-i], 1'b0);
        chk("fill_q", q, 8'h4B);

        // Reset in the middle of a rotate sequence, then resume rotating.
        step("load2d", 1'b0, 1'b1, 3'd3, 8'h2D, 1'b0, 1'b0);
        step("rst_mid", 1'b1, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        chk("rst_mid_q", q, 8'hA5);
        chk("rst_mid_sout", {7'd0, sout}, 8'd0);
        step("ror", 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
        chk("ror_q", q, 8'hD2);
        chk("ror_sout", {7'd0, sout}, 8'd1);

        // Unused inputs at X must not disturb hold.
        step("hold_x", 1'b0, 1'b1, 3'd0, 8'hx, 1'bx, 1'bx);
        chk("hold_x_q", q, 8'hD2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised, clocked successor to the team's gate-level D storage element: a WIDTH-bit register bank with true and complement outputs (q, q_b).
- Eight operating modes: hold, shift right/left, parallel load, rotate right/left, clear and invert.
- Used as the general-purpose storage/serialiser primitive in the library.
- Registers are edge-triggered on clk. Level-sensitive transparency is not supported.

Parameters:
- WIDTH, 8, register width in bits; legal range >= 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high; overrides all other inputs
- en  input  1  operation enable; 0 = hold regardless of mode
- mode  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial input entering the MSB on shift right
- sin_l  input  1  serial input entering the LSB on shift left
- q  output  WIDTH  register contents
- q_b  output  WIDTH  bitwise complement of q, always
- sout  output  1  registered copy of the bit last shifted or rotated out
- busy  output  1  high for the cycle after any non-hold operation

Behaviour:
- All state updates occur on the rising edge of clk only. There is no combinational path from inputs to outputs.
- Priority at each edge: rst > en=0 > mode.
- Reset (rst=1 at edge): q=RESET_VAL, q_b=~RESET_VAL, sout=0, busy=0. Applies from the next edge. A reset mid-sequence discards the operation in progress; no partial update.
- en=0: q, q_b and sout hold; busy=0.
- en=1, mode decode:
  - 000 hold: q unchanged; sout unchanged; busy=0.
  - 001 shift right: q <= {sin_r, q[WIDTH-1:1]}; sout <= old q[0].
  - 010 shift left: q <= {q[WIDTH-2:0], sin_l}; sout <= old q[WIDTH-1].
  - 011 parallel load: q <= d; sout unchanged.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}; sout <= old q[0].
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= old q[WIDTH-1].
  - 110 clear: q <= 0; sout <= 0.
  - 111 invert: q <= ~q; sout unchanged.
- busy <= 1 for any en=1 with mode != 000, else 0. busy is high exactly one cycle per operation and stays high across back-to-back operations.
- Latency: one clock from the sampled inputs to the updated q, q_b, sout and busy.
- q_b is derived from the same registered value as q and is never an independent flop. q ^ q_b == all-ones at all times after the first clock edge.
- sin_r and sin_l are ignored in every mode except their own shift mode.
- Wrap-around: rotate by WIDTH consecutive cycles returns the original value. WIDTH consecutive shifts fully replace contents with serial input.
- Mode may change every cycle. Each edge acts only on the mode sampled at that edge.
- No X propagation from unused inputs. With d or sin_* at X, only modes that consume them produce X.

Test Plan:
- WIDTH=8, RESET_VAL=8'hA5. Assert rst for 1 cycle with en=1, mode=011, d=8'hFF → q=8'hA5, q_b=8'h5A, sout=0, busy=0 (reset wins).
- Load 8'h81 (mode 011) → q=8'h81. Then shift right with sin_r=0 for 1 cycle → q=8'h40, sout=1, busy=1. Then shift left with sin_l=1 → q=8'h81, sout=0.
- Load 8'h96. Rotate left 8 cycles → q=8'h96 again. sout sequence is 1,0,0,1,0,1,1,0 and busy stays 1 throughout.
- Load 8'h3C, then drive en=0 with mode=110 for 3 cycles → q stays 8'h3C, busy=0. Then en=1, mode=111 → q=8'hC3, q_b=8'h3C.
- Serial fill: q=8'h00, shift right 8 cycles with sin_r pattern 1,1,0,1,0,0,1,0 → q=8'h4B.
- Assert rst during a rotate sequence at q=8'h2D → the next q is 8'hA5, sout=0, and the rotate resumes from 8'hA5 once rst drops.
